adc_frame_sequencer: RTL

Parametrised successor to the LVDS ADC phase sequencer. It runs on the ADC bit clock and locks to the ADC frame clock through an acquisition state machine. Once locked it keeps checking frame alignment and re-acquires on loss of lock. It generates run-time programmable ADC/FFT/memory strobes, a time-multiplexed channel index and a wrapping spectrum-line frame counter. It sits between the LVDS deserialiser and the FFT/logfn/memory pipeline.

---
 rtl/rasm_seq_pkg.sv | 16 +
 rtl/frame_lock_fsm.sv | 108 ++++++++++
 rtl/adc_frame_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rasm_seq_pkg.sv
// Shared types and constants for the ADC frame sequencer.
package rasm_seq_pkg;

    // Acquisition / tracking states of the frame-lock FSM.
    typedef enum logic [1:0] {
        ACQ_LOW  = 2'd0,
        ACQ_HIGH = 2'd1,
        CONFIRM  = 2'd2,
        RUN      = 2'd3
    } seq_state_t;

    // All-ones phase select; slice to [PW-1:0] to park a strobe.
    // Any value >= DIV disables a strobe, and all-ones is always >= DIV.
    localparam logic [31:0] PHASE_OFF = '1;

endpackage

// File: rtl/frame_lock_fsm.sv
// Frame-clock lock FSM: acquires alignment to the ADC frame clock, runs the
// bit-phase counter and drops lock after MISS_LIMIT consecutive bad frames.
module frame_lock_fsm
    import rasm_seq_pkg::*;
#(
    parameter int DIV        = 3,
    parameter int PW         = 4,
    parameter int MISS_LIMIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_frame_clk,
    output logic          o_run,
    output logic [PW-1:0] o_phase,
    output logic          o_drop,
    output logic          o_sync_lost
);

    localparam int            MW       = $clog2(MISS_LIMIT + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_EDGE  = PW'(DIV - 2);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

    seq_state_t    r_state;
    logic [PW-1:0] r_phase;
    logic [MW-1:0] r_miss;
    logic          r_fc_prev;
    logic          r_edge_ok;
    logic          r_edge_bad;
    logic          r_sync_lost;

    logic          w_edge;
    logic          w_frame_good;
    logic [MW-1:0] w_miss_inc;

    // A rising edge is judged on the sample arriving this cycle against the last one.
    assign w_edge       = i_frame_clk & ~r_fc_prev;
    // An edge on the last phase itself makes the frame bad.
    assign w_frame_good = r_edge_ok & ~r_edge_bad & ~w_edge;
    assign w_miss_inc   = r_miss + MW'(1);

    assign o_run       = (r_state == RUN);
    assign o_phase     = r_phase;
    assign o_sync_lost = r_sync_lost;
    // Asserted during the evaluation cycle that is about to drop lock.
    assign o_drop      = (r_state == RUN) && (r_phase == PH_LAST) &&
                         !w_frame_good && (w_miss_inc == MISS_MAX);

    // Lock FSM, phase counter, per-frame edge bookkeeping and miss counter.
    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ACQ_LOW;
            r_phase     <= '0;
            r_miss      <= '0;
            r_fc_prev   <= 1'b0;
            r_edge_ok   <= 1'b0;
            r_edge_bad  <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_fc_prev   <= i_frame_clk;
            r_sync_lost <= 1'b0;
            case (r_state)
                ACQ_LOW: begin
                    if (!i_frame_clk) r_state <= ACQ_HIGH;
                end
                ACQ_HIGH: begin
                    if (i_frame_clk) r_state <= CONFIRM;
                end
                CONFIRM: begin
                    if (i_frame_clk) begin
                        r_state    <= RUN;
                        r_phase    <= '0;
                        r_miss     <= '0;
                        r_edge_ok  <= 1'b0;
                        r_edge_bad <= 1'b0;
                    end else begin
                        r_state <= ACQ_LOW;
                    end
                end
                RUN: begin
                    if (r_phase == PH_LAST) begin
                        r_phase    <= '0;
                        r_edge_ok  <= 1'b0;
                        r_edge_bad <= 1'b0;
                        if (w_frame_good) begin
                            r_miss <= '0;
                        end else if (w_miss_inc == MISS_MAX) begin
                            r_state     <= ACQ_LOW;
                            r_miss      <= '0;
                            r_sync_lost <= 1'b1;
                        end else begin
                            r_miss <= w_miss_inc;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                        if (w_edge) begin
                            if (r_phase == PH_EDGE) r_edge_ok  <= 1'b1;
                            else                    r_edge_bad <= 1'b1;
                        end
                    end
                end
                default: r_state <= ACQ_LOW;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_sequencer.sv
// ADC frame sequencer: locks to the LVDS frame clock and generates the
// ADC/FFT/memory strobes, the channel index and the spectrum-line frame counter.
module adc_frame_sequencer
    import rasm_seq_pkg::*;
#(
    parameter  int DIV         = 3,
    parameter  int PW          = 4,
    parameter  int NCH         = 2,
    parameter  int MEMORYWIDTH = 10,
    parameter  int LINE_LEN    = 2 ** MEMORYWIDTH,
    parameter  int MISS_LIMIT  = 4,
    localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   i_lvds_bitClk,
    input  logic                   i_rst_n,
    input  logic                   i_lvds_frameClk,
    input  logic                   i_fft_lineSync,
    input  logic [PW-1:0]          i_adcPhase,
    input  logic [PW-1:0]          i_fftPhase,
    input  logic [PW-1:0]          i_memPhase,
    output logic                   o_adc_frameStrobe,
    output logic                   o_fft_frameStrobe,
    output logic                   o_mem_sampleStrobe,
    output logic [CW-1:0]          o_channel,
    output logic [MEMORYWIDTH-1:0] o_frameCounter,
    output logic                   o_lineWrap,
    output logic                   o_locked,
    output logic                   o_syncLost
);

    localparam logic [CW-1:0]          CH_LAST   = CW'(NCH - 1);
    localparam logic [MEMORYWIDTH-1:0] LINE_LAST = MEMORYWIDTH'(LINE_LEN - 1);

    logic          w_run;
    logic          w_drop;
    logic          w_gate;
    logic [PW-1:0] w_phase;

    logic                   r_adc_tmp, r_fft_tmp, r_mem_tmp;
    logic                   r_adc_strobe, r_fft_strobe, r_mem_strobe;
    logic [CW-1:0]          r_chan, r_channel;
    logic [MEMORYWIDTH-1:0] r_frame_cnt, r_frame_out;
    logic                   r_wrap_int, r_line_wrap;

    frame_lock_fsm #(
        .DIV        (DIV),
        .PW         (PW),
        .MISS_LIMIT (MISS_LIMIT)
    ) u_lock (
        .i_clk       (i_lvds_bitClk),
        .i_rst_n     (i_rst_n),
        .i_frame_clk (i_lvds_frameClk),
        .o_run       (w_run),
        .o_phase     (w_phase),
        .o_drop      (w_drop),
        .o_sync_lost (o_syncLost)
    );

    // Strobes already in the pipe are squashed as soon as lock is being dropped.
    assign w_gate = w_run & ~w_drop;

    // First strobe stage: phase match against the live phase-select inputs.
    always_ff @(posedge i_lvds_bitClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_adc_tmp <= 1'b0;
            r_fft_tmp <= 1'b0;
            r_mem_tmp <= 1'b0;
        end else begin
            r_adc_tmp <= w_run && (w_phase == i_adcPhase);
            r_fft_tmp <= w_run && (w_phase == i_fftPhase);
            r_mem_tmp <= w_run && (w_phase == i_memPhase);
        end
    end

    // Output strobe registers, gated off once lock is gone.
    always_ff @(posedge i_lvds_bitClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_adc_strobe <= 1'b0;
            r_fft_strobe <= 1'b0;
            r_mem_strobe <= 1'b0;
        end else begin
            r_adc_strobe <= r_adc_tmp & w_gate;
            r_fft_strobe <= r_fft_tmp & w_gate;
            r_mem_strobe <= r_mem_tmp & w_gate;
        end
    end

    // Channel index: restarts at 0 each lock, advances per ADC strobe and
    // is published in the same cycle as the strobe it belongs to.
    always_ff @(posedge i_lvds_bitClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chan    <= '0;
            r_channel <= '0;
        end else begin
            if (!w_run) begin
                r_chan <= '0;
            end else if (r_adc_tmp) begin
                r_chan <= (r_chan == CH_LAST) ? '0 : r_chan + 1'b1;
            end
            if (r_adc_tmp & w_gate) r_channel <= r_chan;
        end
    end

    // Frame counter: steps at phase 0 of each frame; lineSync beats the wrap.
    // The count is kept across lock loss so a re-lock continues the line.
    always_ff @(posedge i_lvds_bitClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
            r_wrap_int  <= 1'b0;
        end else begin
            r_wrap_int <= 1'b0;
            if (w_run && (w_phase == '0)) begin
                if (i_fft_lineSync) begin
                    r_frame_cnt <= '0;
                end else if (r_frame_cnt == LINE_LAST) begin
                    r_frame_cnt <= '0;
                    r_wrap_int  <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Output register stage for the counter and its wrap pulse.
    always_ff @(posedge i_lvds_bitClk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_out <= '0;
            r_line_wrap <= 1'b0;
        end else begin
            r_frame_out <= r_frame_cnt;
            r_line_wrap <= r_wrap_int;
        end
    end

    assign o_adc_frameStrobe  = r_adc_strobe;
    assign o_fft_frameStrobe  = r_fft_strobe;
    assign o_mem_sampleStrobe = r_mem_strobe;
    assign o_channel          = r_channel;
    assign o_frameCounter     = r_frame_out;
    assign o_lineWrap         = r_line_wrap;
    assign o_locked           = w_run;

endmodule
